// File: rtl/skid_pipe_pkg.sv
// Shared types and helpers for the skid_pipe valid/ready pipeline.
package skid_pipe_pkg;

    // Per-stage occupancy: no word, one word in main, two words (main + skid).
    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_BUSY  = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_t;

    // Width of the occupancy count for a chain of 'depth' stages (never 0 bits).
    function automatic int occ_width(input int depth);
        int w;
        w = $clog2(2 * depth + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/skid_stage.sv
// One skid stage: main + skid register, 3-state FSM, registered valid/ready.
// Holds up to two words so the upstream ready can be a flop without losing data.
module skid_stage
    import skid_pipe_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter bit RST_DATA = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready
);

    skid_state_t      state_q, state_d;
    logic [WIDTH-1:0] main_q, skid_q;
    logic             valid_q, ready_q;
    logic             load_in, load_skid, load_from_skid;

    // Next-state and load decode for the stage FSM.
    // NOTE: every output of this block is given a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d        = state_q;
        load_in        = 1'b0;
        load_skid      = 1'b0;
        load_from_skid = 1'b0;
        case (state_q)
            SKID_EMPTY: begin
                if (i_valid) begin
                    state_d = SKID_BUSY;
                    load_in = 1'b1;
                end
            end
            SKID_BUSY: begin
                if (i_valid && i_ready) begin
                    load_in = 1'b1;
                end else if (i_valid) begin
                    state_d   = SKID_FULL;
                    load_skid = 1'b1;
                end else if (i_ready) begin
                    state_d = SKID_EMPTY;
                end
            end
            SKID_FULL: begin
                // Upstream sees ready=0 here, so i_valid is ignored.
                if (i_ready) begin
                    state_d        = SKID_BUSY;
                    load_from_skid = 1'b1;
                end
            end
            default: state_d = SKID_EMPTY;
        endcase
    end

    // Control state plus flopped valid/ready decoded from the next state.
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= SKID_EMPTY;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            valid_q <= (state_d != SKID_EMPTY);
            ready_q <= (state_d != SKID_FULL);
        end
    end

    // Data registers change only on a load.
    // NOTE: with RST_DATA=0 the data regs hold through reset; only control state is cleared.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            if (RST_DATA) begin
                main_q <= '0;
                skid_q <= '0;
            end
        end else begin
            if (load_in)        main_q <= i_data;
            if (load_from_skid) main_q <= skid_q;
            if (load_skid)      skid_q <= i_data;
        end
    end

    assign o_valid = valid_q;
    assign o_ready = ready_q;
    assign o_data  = main_q;

endmodule

// File: rtl/skid_pipe.sv
// Multi-stage valid/ready pipeline built from a chain of skid_stage instances.
// DEPTH=0 gives a combinational passthrough. Optional occupancy output is
// enabled with the SKID_PIPE_OCC_EN macro.
module skid_pipe
    import skid_pipe_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 2,
    parameter bit RST_DATA = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready
`ifdef SKID_PIPE_OCC_EN
    ,
    output logic [occ_width(DEPTH)-1:0] o_occ
`endif
);

    if (DEPTH == 0) begin : g_bypass
        // No storage: clock and reset are intentionally unconnected here.
        logic unused_clk_rst;
        assign unused_clk_rst = i_clk ^ i_rst_n;
        assign o_data  = i_data;
        assign o_valid = i_valid;
        assign o_ready = i_ready;
    end else begin : g_chain
        // Index k is the interface feeding stage k; index DEPTH is the output.
        logic [WIDTH-1:0] chain_data [DEPTH+1];
        logic [DEPTH:0]   chain_valid;
        logic [DEPTH:0]   chain_ready;

        assign chain_data[0]      = i_data;
        assign chain_valid[0]     = i_valid;
        assign chain_ready[DEPTH] = i_ready;
        assign o_ready            = chain_ready[0];
        assign o_data             = chain_data[DEPTH];
        assign o_valid            = chain_valid[DEPTH];

        for (genvar k = 0; k < DEPTH; k++) begin : g_stage
            skid_stage #(
                .WIDTH    (WIDTH),
                .RST_DATA (RST_DATA)
            ) u_stage (
                .i_clk   (i_clk),
                .i_rst_n (i_rst_n),
                .i_data  (chain_data[k]),
                .i_valid (chain_valid[k]),
                .o_ready (chain_ready[k]),
                .o_data  (chain_data[k+1]),
                .o_valid (chain_valid[k+1]),
                .i_ready (chain_ready[k+1])
            );
        end
    end

`ifdef SKID_PIPE_OCC_EN
    localparam int OW = occ_width(DEPTH);

    if (DEPTH == 0) begin : g_occ_none
        assign o_occ = '0;
    end else begin : g_occ
        localparam logic [OW-1:0] OCC_ONE = OW'(1);
        localparam logic [OW-1:0] OCC_MAX = OW'(2 * DEPTH);

        logic          in_xfer, out_xfer;
        logic [OW-1:0] occ_q;

        assign in_xfer  = i_valid && o_ready;
        assign out_xfer = o_valid && i_ready;

        // Word count across all stages: +1 on accept, -1 on emit, both = no change.
        always_ff @(posedge i_clk) begin
            if (!i_rst_n) begin
                occ_q <= '0;
            end else begin
                case ({in_xfer, out_xfer})
                    2'b10:   occ_q <= occ_q + OCC_ONE;
                    2'b01:   occ_q <= occ_q - OCC_ONE;
                    default: occ_q <= occ_q;
                endcase
            end
        end

        assign o_occ = occ_q;

        a_occ_bound: assert property (@(posedge i_clk) disable iff (!i_rst_n) occ_q <= OCC_MAX);
    end
`endif

endmodule

// File: tb/tb_skid_pipe.sv
// Self-checking bench for skid_pipe: DEPTH=2 directed table and streams,
// mid-run reset, DEPTH=0 passthrough, DEPTH=3 randomized run against a
// per-stage two-entry queue model plus an in-order scoreboard.
module tb_skid_pipe;
    import skid_pipe_pkg::*;

    localparam int W = 16;

    logic i_clk;
    logic i_rst_n;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // DEPTH=2 instance
    logic [W-1:0] d2_i_data, d2_o_data;
    logic         d2_i_valid, d2_i_ready, d2_o_valid, d2_o_ready;
    // DEPTH=3 instance
    logic [W-1:0] d3_i_data, d3_o_data;
    logic         d3_i_valid, d3_i_ready, d3_o_valid, d3_o_ready;
    // DEPTH=0 instance
    logic [W-1:0] d0_i_data, d0_o_data;
    logic         d0_i_valid, d0_i_ready, d0_o_valid, d0_o_ready;
`ifdef SKID_PIPE_OCC_EN
    logic [occ_width(2)-1:0] d2_o_occ;
    logic [occ_width(3)-1:0] d3_o_occ;
    logic [occ_width(0)-1:0] d0_o_occ;
`endif

    skid_pipe #(.WIDTH(W), .DEPTH(2), .RST_DATA(1'b1)) dut2 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_data(d2_i_data), .i_valid(d2_i_valid),
        .o_ready(d2_o_ready), .o_data(d2_o_data), .o_valid(d2_o_valid), .i_ready(d2_i_ready)
`ifdef SKID_PIPE_OCC_EN
        , .o_occ(d2_o_occ)
`endif
    );

    skid_pipe #(.WIDTH(W), .DEPTH(3), .RST_DATA(1'b1)) dut3 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_data(d3_i_data), .i_valid(d3_i_valid),
        .o_ready(d3_o_ready), .o_data(d3_o_data), .o_valid(d3_o_valid), .i_ready(d3_i_ready)
`ifdef SKID_PIPE_OCC_EN
        , .o_occ(d3_o_occ)
`endif
    );

    skid_pipe #(.WIDTH(W), .DEPTH(0), .RST_DATA(1'b1)) dut0 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_data(d0_i_data), .i_valid(d0_i_valid),
        .o_ready(d0_o_ready), .o_data(d0_o_data), .o_valid(d0_o_valid), .i_ready(d0_i_ready)
`ifdef SKID_PIPE_OCC_EN
        , .o_occ(d0_o_occ)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Directed vector: inputs for one cycle and the outputs expected in that cycle.
    typedef struct {
        logic         vin;
        logic [W-1:0] din;
        logic         rdy;
        logic         exp_v;
        logic [W-1:0] exp_d;
        logic         exp_r;
        int           exp_occ;
    } vec_t;

    vec_t tbl [20];

    // Stream n words starting at base with i_ready=1; DEPTH=2 so each word
    // appears two cycles after it is accepted.
    task automatic run_stream(input string tag, input logic [W-1:0] base, input int n);
        int accepted, emitted;
        for (int t = 0; t < n + 4; t++) begin
            @(negedge i_clk);
            d2_i_valid = (t < n);
            d2_i_data  = base + W'(t);
            d2_i_ready = 1'b1;
            #1;
            check({tag, "_ready"}, 32'(d2_o_ready), 32'(1));
            check({tag, "_valid"}, 32'(d2_o_valid), 32'((t >= 2) && (t < n + 2)));
            if ((t >= 2) && (t < n + 2))
                check({tag, "_data"}, 32'(d2_o_data), 32'(base + W'(t - 2)));
            accepted = (t < n) ? t : n;
            emitted  = (t < 2) ? 0 : (((t < n + 2) ? t : n + 2) - 2);
`ifdef SKID_PIPE_OCC_EN
            check({tag, "_occ"}, 32'(d2_o_occ), 32'(accepted - emitted));
`else
            if (accepted < emitted) check({tag, "_count"}, 32'(accepted), 32'(emitted));
`endif
        end
        d2_i_valid = 1'b0;
    endtask

    // Reference model for DEPTH=3: each stage is a queue of at most two words.
    localparam int MD = 3;
    logic [W-1:0] m_data [MD][2];
    int           m_cnt  [MD];
    logic [W-1:0] sb_q [$];
    int           emitted3;
    logic         prev_hold;
    logic [W-1:0] prev_data;

    task automatic model_edge(input logic v, input logic [W-1:0] d, input logic r);
        logic         in_x  [MD];
        logic         out_x [MD];
        logic [W-1:0] din   [MD];
        for (int k = 0; k < MD; k++) begin
            logic up_v, dn_r;
            up_v     = (k == 0) ? v : (m_cnt[k-1] > 0);
            din[k]   = (k == 0) ? d : m_data[k-1][0];
            dn_r     = (k == MD - 1) ? r : (m_cnt[k+1] < 2);
            in_x[k]  = up_v && (m_cnt[k] < 2);
            out_x[k] = (m_cnt[k] > 0) && dn_r;
        end
        for (int k = 0; k < MD; k++) begin
            if (out_x[k]) begin
                m_data[k][0] = m_data[k][1];
                m_cnt[k]--;
            end
            if (in_x[k]) begin
                m_data[k][m_cnt[k]] = din[k];
                m_cnt[k]++;
            end
        end
    endtask

    task automatic rand_cycle(input logic v, input logic [W-1:0] d, input logic r);
        logic         ev, er;
        logic [W-1:0] ed;
        int           occ;
        @(negedge i_clk);
        d3_i_valid = v;
        d3_i_data  = d;
        d3_i_ready = r;
        #1;
        ev  = (m_cnt[MD-1] > 0);
        ed  = m_data[MD-1][0];
        er  = (m_cnt[0] < 2);
        occ = m_cnt[0] + m_cnt[1] + m_cnt[2];
        check("rnd_valid", 32'(d3_o_valid), 32'(ev));
        check("rnd_ready", 32'(d3_o_ready), 32'(er));
        if (ev) check("rnd_data", 32'(d3_o_data), 32'(ed));
`ifdef SKID_PIPE_OCC_EN
        check("rnd_occ", 32'(d3_o_occ), 32'(occ));
`endif
        if (prev_hold) begin
            check("rnd_stable_v", 32'(d3_o_valid), 32'(1));
            check("rnd_stable_d", 32'(d3_o_data), 32'(prev_data));
        end
        // Scoreboard: order of accepted words must be preserved exactly.
        if (v && er) sb_q.push_back(d);
        if (d3_o_valid && r) begin
            if (sb_q.size() == 0) begin
                check("rnd_sb_empty", 32'(1), 32'(0));
            end else begin
                check("rnd_order", 32'(d3_o_data), 32'(sb_q.pop_front()));
            end
            emitted3++;
        end
        prev_hold = d3_o_valid && !r;
        prev_data = d3_o_data;
        model_edge(v, d, r);
    endtask

    initial begin
        // Capacity/drain/resume table for DEPTH=2.
        tbl[0]  = '{1'b1, 16'hA001, 1'b0, 1'b0, 16'h0000, 1'b1, 0};
        tbl[1]  = '{1'b1, 16'hA002, 1'b0, 1'b0, 16'h0000, 1'b1, 1};
        tbl[2]  = '{1'b1, 16'hA003, 1'b0, 1'b1, 16'hA001, 1'b1, 2};
        tbl[3]  = '{1'b1, 16'hA004, 1'b0, 1'b1, 16'hA001, 1'b1, 3};
        for (int i = 4; i < 10; i++)
            tbl[i] = '{1'b1, 16'hA005, 1'b0, 1'b1, 16'hA001, 1'b0, 4};
        tbl[10] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'hA001, 1'b0, 4};
        tbl[11] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'hA002, 1'b0, 3};
        tbl[12] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'hA003, 1'b1, 2};
        tbl[13] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'hA004, 1'b1, 1};
        tbl[14] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 0};
        tbl[15] = '{1'b1, 16'hA005, 1'b1, 1'b0, 16'h0000, 1'b1, 0};
        tbl[16] = '{1'b1, 16'hA006, 1'b1, 1'b0, 16'h0000, 1'b1, 1};
        tbl[17] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'hA005, 1'b1, 2};
        tbl[18] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'hA006, 1'b1, 1};
        tbl[19] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 0};

        for (int k = 0; k < MD; k++) begin
            m_cnt[k]     = 0;
            m_data[k][0] = '0;
            m_data[k][1] = '0;
        end
        emitted3  = 0;
        prev_hold = 1'b0;
        prev_data = '0;

        i_rst_n    = 1'b0;
        d2_i_data  = '0; d2_i_valid = 1'b0; d2_i_ready = 1'b0;
        d3_i_data  = '0; d3_i_valid = 1'b0; d3_i_ready = 1'b0;
        d0_i_data  = '0; d0_i_valid = 1'b0; d0_i_ready = 1'b0;
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        #1;

        // Reset state.
        check("rst_d2_valid", 32'(d2_o_valid), 32'(0));
        check("rst_d2_ready", 32'(d2_o_ready), 32'(1));
        check("rst_d2_data",  32'(d2_o_data),  32'(0));
        check("rst_d3_valid", 32'(d3_o_valid), 32'(0));
        check("rst_d3_ready", 32'(d3_o_ready), 32'(1));
`ifdef SKID_PIPE_OCC_EN
        check("rst_d2_occ", 32'(d2_o_occ), 32'(0));
        check("rst_d3_occ", 32'(d3_o_occ), 32'(0));
`endif

        // Back-to-back stream 0x0001..0x0010.
        run_stream("stream", 16'h0001, 16);

        // Fill to capacity, hold, drain in order, resume.
        for (int i = 0; i < 20; i++) begin
            @(negedge i_clk);
            d2_i_valid = tbl[i].vin;
            d2_i_data  = tbl[i].din;
            d2_i_ready = tbl[i].rdy;
            #1;
            check($sformatf("tbl%0d_valid", i), 32'(d2_o_valid), 32'(tbl[i].exp_v));
            check($sformatf("tbl%0d_ready", i), 32'(d2_o_ready), 32'(tbl[i].exp_r));
            if (tbl[i].exp_v)
                check($sformatf("tbl%0d_data", i), 32'(d2_o_data), 32'(tbl[i].exp_d));
`ifdef SKID_PIPE_OCC_EN
            check($sformatf("tbl%0d_occ", i), 32'(d2_o_occ), 32'(tbl[i].exp_occ));
`endif
        end

        // Fill 4 words, then reset with a same-cycle transfer offered.
        for (int i = 0; i < 4; i++) begin
            @(negedge i_clk);
            d2_i_valid = 1'b1;
            d2_i_data  = 16'hB001 + W'(i);
            d2_i_ready = 1'b0;
        end
        @(negedge i_clk);
        d2_i_valid = 1'b1;
        d2_i_data  = 16'hB005;
        d2_i_ready = 1'b1;
        i_rst_n    = 1'b0;
        #1;
        check("full_ready", 32'(d2_o_ready), 32'(0));
        check("full_data",  32'(d2_o_data),  32'(16'hB001));
`ifdef SKID_PIPE_OCC_EN
        check("full_occ", 32'(d2_o_occ), 32'(4));
`endif
        @(negedge i_clk);
        i_rst_n    = 1'b1;
        d2_i_valid = 1'b0;
        #1;
        check("mrst_valid", 32'(d2_o_valid), 32'(0));
        check("mrst_ready", 32'(d2_o_ready), 32'(1));
        check("mrst_data",  32'(d2_o_data),  32'(0));
`ifdef SKID_PIPE_OCC_EN
        check("mrst_occ", 32'(d2_o_occ), 32'(0));
`endif
        run_stream("post_rst", 16'hC001, 5);

        // DEPTH=0 passthrough.
        for (int i = 0; i < 16; i++) begin
            @(negedge i_clk);
            d0_i_valid = 1'($urandom_range(0, 1));
            d0_i_ready = 1'($urandom_range(0, 1));
            d0_i_data  = W'($urandom);
            #1;
            check("bypass_data",  32'(d0_o_data),  32'(d0_i_data));
            check("bypass_valid", 32'(d0_o_valid), 32'(d0_i_valid));
            check("bypass_ready", 32'(d0_o_ready), 32'(d0_i_ready));
`ifdef SKID_PIPE_OCC_EN
            check("bypass_occ", 32'(d0_o_occ), 32'(0));
`endif
        end

        // DEPTH=3 randomized run: 10k words at 50% valid / 50% ready.
        begin
            int cyc;
            cyc = 0;
            while (emitted3 < 10000 && cyc < 60000) begin
                rand_cycle(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)));
                cyc++;
            end
            check("rnd_budget", 32'(emitted3 >= 10000), 32'(1));
            for (int i = 0; i < 12; i++) rand_cycle(1'b0, '0, 1'b1);
            check("rnd_drained", 32'(sb_q.size()), 32'(0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
